boot_ctrl: RTL and testbench

BOOT_CTRL -- requirements
Module: boot_ctrl

---
 rtl/boot_ctrl_pkg.sv | 42 ++++
 rtl/boot_ctrl_regs.sv | 100 ++++++++++
 rtl/boot_ctrl.sv | 140 ++++++++++++++
 tb/tb_boot_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/boot_ctrl_pkg.sv
// rtl/boot_ctrl_pkg.sv - shared register map, status layout and FSM encoding for boot_ctrl
`timescale 1ns/1ps
package boot_ctrl_pkg;

    // Register offsets relative to BASE_ADDR
    localparam logic [15:0] OFF_STATUS      = 16'h0000;
    localparam logic [15:0] OFF_CTRL        = 16'h0004;
    localparam logic [15:0] OFF_DRAMBASE    = 16'h0008;
    localparam logic [15:0] OFF_ENTRYPC     = 16'h000C;
    localparam logic [15:0] OFF_TOHOST_ADDR = 16'h0010;
    localparam logic [15:0] OFF_TOHOST_VAL  = 16'h0014;
    localparam logic [15:0] OFF_CYCLES      = 16'h0018;

    // STATUS bit positions
    localparam int STAT_RUN       = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_PASS      = 2;
    localparam int STAT_HOLD      = 3;
    localparam int STAT_STATE_LSB = 4;

    localparam logic [31:0] TOHOST_ADDR_RST = 32'h8000_1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    // Replace only the bytes selected by be
    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/boot_ctrl_regs.sv
// rtl/boot_ctrl_regs.sv - regbus decode, byte-enable merge and registered read mux
`timescale 1ns/1ps
module boot_ctrl_regs
    import boot_ctrl_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h1000
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [15:0] WRADDR,
    input  logic [3:0]  BYTEEN,
    input  logic        WREN,
    input  logic [31:0] WDATA,
    input  logic [15:0] RDADDR,
    input  logic        RDEN,
    output logic [31:0] RDATA,
    input  logic [31:0] status,
    input  logic [31:0] tohost_val,
    input  logic [31:0] cycles,
    output logic        hold_reset,
    output logic        start,
    output logic [31:0] drambase,
    output logic [31:0] entrypc,
    output logic [31:0] tohost_addr
);

    logic [15:0] wr_off, rd_off;
    logic        hold_q, hold_d;
    logic        start_q, start_d;
    logic [31:0] drambase_q, drambase_d;
    logic [31:0] entrypc_q, entrypc_d;
    logic [31:0] tohost_addr_q, tohost_addr_d;
    logic [31:0] rdata_q, rdata_d;

    assign wr_off = WRADDR - BASE_ADDR;
    assign rd_off = RDADDR - BASE_ADDR;

    // Write decode with byte merge; read mux samples the pre-write register values
    always_comb begin
        hold_d        = hold_q;
        start_d       = 1'b0;
        drambase_d    = drambase_q;
        entrypc_d     = entrypc_q;
        tohost_addr_d = tohost_addr_q;
        rdata_d       = rdata_q;
        if (WREN) begin
            case (wr_off)
                OFF_CTRL: begin
                    if (BYTEEN[0]) begin
                        hold_d  = WDATA[0];
                        start_d = WDATA[1];
                    end
                end
                OFF_DRAMBASE:    drambase_d    = be_merge(drambase_q, WDATA, BYTEEN);
                OFF_ENTRYPC:     entrypc_d     = be_merge(entrypc_q, WDATA, BYTEEN);
                OFF_TOHOST_ADDR: tohost_addr_d = be_merge(tohost_addr_q, WDATA, BYTEEN);
                default: ;
            endcase
        end
        if (RDEN) begin
            case (rd_off)
                OFF_STATUS:      rdata_d = status;
                OFF_CTRL:        rdata_d = {31'b0, hold_q};
                OFF_DRAMBASE:    rdata_d = drambase_q;
                OFF_ENTRYPC:     rdata_d = entrypc_q;
                OFF_TOHOST_ADDR: rdata_d = tohost_addr_q;
                OFF_TOHOST_VAL:  rdata_d = tohost_val;
                OFF_CYCLES:      rdata_d = cycles;
                default:         rdata_d = 32'b0;
            endcase
        end
    end

    // Register storage
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            hold_q        <= 1'b0;
            start_q       <= 1'b0;
            drambase_q    <= 32'b0;
            entrypc_q     <= 32'b0;
            tohost_addr_q <= TOHOST_ADDR_RST;
            rdata_q       <= 32'b0;
        end else begin
            hold_q        <= hold_d;
            start_q       <= start_d;
            drambase_q    <= drambase_d;
            entrypc_q     <= entrypc_d;
            tohost_addr_q <= tohost_addr_d;
            rdata_q       <= rdata_d;
        end
    end

    assign RDATA       = rdata_q;
    assign hold_reset  = hold_q;
    assign start       = start_q;
    assign drambase    = drambase_q;
    assign entrypc     = entrypc_q;
    assign tohost_addr = tohost_addr_q;

endmodule

// File: rtl/boot_ctrl.sv
// rtl/boot_ctrl.sv - CPU boot sequencer: reset pulse, run, tohost snoop and halt
`timescale 1ns/1ps
module boot_ctrl
    import boot_ctrl_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'h1000,
    parameter int          RST_CYCLES = 16
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [15:0] WRADDR,
    input  logic [3:0]  BYTEEN,
    input  logic        WREN,
    input  logic [31:0] WDATA,
    input  logic [15:0] RDADDR,
    input  logic        RDEN,
    output logic [31:0] RDATA,
    input  logic        mon_wvalid,
    input  logic [31:0] mon_waddr,
    input  logic [31:0] mon_wdata,
    output logic        cpu_rst_n,
    output logic [31:0] dram_base,
    output logic [31:0] entry_pc
);

    logic        hold_reset, start;
    logic [31:0] drambase, entrypc, tohost_addr, status;
    state_e      state_q, state_d;
    logic [15:0] rst_cnt_q, rst_cnt_d;
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] tohost_val_q, tohost_val_d;
    logic [31:0] dram_base_q, dram_base_d;
    logic [31:0] entry_pc_q, entry_pc_d;
    logic        done_q, done_d, pass_q, pass_d;
    logic        cpu_rst_n_q, cpu_rst_n_d;
    logic        snoop_hit, rst_entry;

    boot_ctrl_regs #(.BASE_ADDR(BASE_ADDR)) u_regs (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WDATA(WDATA),
        .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA),
        .status(status), .tohost_val(tohost_val_q), .cycles(cycles_q),
        .hold_reset(hold_reset), .start(start),
        .drambase(drambase), .entrypc(entrypc), .tohost_addr(tohost_addr)
    );

    // A passing or failing tohost store; a concurrent HOLD takes precedence
    assign snoop_hit = (state_q == ST_RUN) && !hold_reset && mon_wvalid &&
                       (mon_waddr == tohost_addr) && mon_wdata[0];

    // State register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; HOLD overrides every transition
    always_comb begin
        state_d = state_q;
        if (hold_reset) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) state_d = ST_RST;
                ST_RST:  if (rst_cnt_q == 16'(RST_CYCLES - 1)) state_d = ST_RUN;
                ST_RUN:  if (snoop_hit) state_d = ST_HALT;
                ST_HALT: if (start) state_d = ST_RST;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs: CPU reset is registered so the core never sees a decode glitch
    always_comb begin
        cpu_rst_n_d = (state_d == ST_RUN);
        status = 32'b0;
        status[STAT_RUN]            = (state_q == ST_RUN);
        status[STAT_DONE]           = done_q;
        status[STAT_PASS]           = pass_q;
        status[STAT_HOLD]           = hold_reset;
        status[STAT_STATE_LSB +: 2] = state_q;
    end

    // Datapath next values: RST entry latches the boot image, counters, tohost capture
    always_comb begin
        rst_entry    = (state_d == ST_RST) && (state_q != ST_RST);
        rst_cnt_d    = (state_q == ST_RST) ? rst_cnt_q + 16'd1 : rst_cnt_q;
        cycles_d     = cycles_q;
        tohost_val_d = tohost_val_q;
        dram_base_d  = dram_base_q;
        entry_pc_d   = entry_pc_q;
        done_d       = done_q;
        pass_d       = pass_q;
        if (rst_entry) begin
            rst_cnt_d    = 16'd0;
            cycles_d     = 32'b0;
            tohost_val_d = 32'b0;
            dram_base_d  = drambase;
            entry_pc_d   = entrypc;
            done_d       = 1'b0;
            pass_d       = 1'b0;
        end else begin
            if (state_q == ST_RUN && cycles_q != 32'hFFFF_FFFF)
                cycles_d = cycles_q + 32'd1;
            if (snoop_hit) begin
                tohost_val_d = mon_wdata;
                done_d       = 1'b1;
                pass_d       = (mon_wdata == 32'd1);
            end
        end
    end

    // Datapath registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rst_cnt_q    <= 16'd0;
            cycles_q     <= 32'b0;
            tohost_val_q <= 32'b0;
            dram_base_q  <= 32'b0;
            entry_pc_q   <= 32'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            cpu_rst_n_q  <= 1'b0;
        end else begin
            rst_cnt_q    <= rst_cnt_d;
            cycles_q     <= cycles_d;
            tohost_val_q <= tohost_val_d;
            dram_base_q  <= dram_base_d;
            entry_pc_q   <= entry_pc_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
        end
    end

    assign cpu_rst_n = cpu_rst_n_q;
    assign dram_base = dram_base_q;
    assign entry_pc  = entry_pc_q;

endmodule

// File: tb/tb_boot_ctrl.sv
// tb/tb_boot_ctrl.sv - directed self-checking bench for boot_ctrl
`timescale 1ns/1ps
module tb_boot_ctrl;

    localparam logic [15:0] BASE = 16'h1000;
    localparam int          RSTC = 16;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [15:0] WRADDR;
    logic [3:0]  BYTEEN;
    logic        WREN;
    logic [31:0] WDATA;
    logic [15:0] RDADDR;
    logic        RDEN;
    logic [31:0] RDATA;
    logic        mon_wvalid;
    logic [31:0] mon_waddr;
    logic [31:0] mon_wdata;
    logic        cpu_rst_n;
    logic [31:0] dram_base;
    logic [31:0] entry_pc;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int cyc_start;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    boot_ctrl #(.BASE_ADDR(BASE), .RST_CYCLES(RSTC)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WDATA(WDATA),
        .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA),
        .mon_wvalid(mon_wvalid), .mon_waddr(mon_waddr), .mon_wdata(mon_wdata),
        .cpu_rst_n(cpu_rst_n), .dram_base(dram_base), .entry_pc(entry_pc)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] off, input logic [31:0] data, input logic [3:0] be);
        WRADDR = BASE + off; WDATA = data; BYTEEN = be; WREN = 1'b1;
        tick();
        WREN = 1'b0; BYTEEN = 4'h0;
    endtask

    task automatic rd(input string tag, input logic [15:0] off, input logic [31:0] exp);
        RDADDR = BASE + off; RDEN = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick();
        RDEN = 1'b0;
        check(tag_q.pop_front(), RDATA, exp_q.pop_front());
    endtask

    task automatic snoop(input logic [31:0] addr, input logic [31:0] data);
        mon_wvalid = 1'b1; mon_waddr = addr; mon_wdata = data;
        tick();
        mon_wvalid = 1'b0;
    endtask

    // Bounded wait for cpu_rst_n to rise; checks the latency from cyc_start
    task automatic wait_rise(input string tag);
        int n;
        n = 0;
        while (cpu_rst_n !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(cyc - cyc_start), 32'(RSTC + 1));
    endtask

    task automatic check_reset_regs(input string pfx);
        rd({pfx, "_status"}, 16'h00, 32'h0);
        rd({pfx, "_ctrl"},   16'h04, 32'h0);
        rd({pfx, "_dram"},   16'h08, 32'h0);
        rd({pfx, "_entry"},  16'h0C, 32'h0);
        rd({pfx, "_thaddr"}, 16'h10, 32'h8000_1000);
        rd({pfx, "_thval"},  16'h14, 32'h0);
        rd({pfx, "_cycles"}, 16'h18, 32'h0);
    endtask

    initial begin
        ARESETN = 1'b0; WRADDR = '0; BYTEEN = '0; WREN = 1'b0; WDATA = '0;
        RDADDR = '0; RDEN = 1'b0; mon_wvalid = 1'b0; mon_waddr = '0; mon_wdata = '0;
        tick(); tick();
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
        check("rst_rdata", RDATA, 32'h0);
        check("rst_dram_base", dram_base, 32'h0);
        check("rst_entry_pc", entry_pc, 32'h0);
        ARESETN = 1'b1;
        tick();
        check_reset_regs("init");
        rd("unmapped", 16'h1C, 32'h0);

        // Byte enables and RO write
        wr(16'h08, 32'hFFFF_FFFF, 4'hF);
        wr(16'h08, 32'h0000_0012, 4'h1);
        rd("be_merge", 16'h08, 32'hFFFF_FF12);
        wr(16'h00, 32'hFFFF_FFFF, 4'hF);
        rd("status_ro", 16'h00, 32'h0);

        // HOLD wins over START from IDLE
        wr(16'h04, 32'h3, 4'h1);
        rd("hold_start_status", 16'h00, 32'h08);
        tick(); tick();
        check("hold_start_cpu", 32'(cpu_rst_n), 32'h0);
        wr(16'h04, 32'h0, 4'h1);
        rd("hold_clr_status", 16'h00, 32'h0);

        // Pass run
        wr(16'h08, 32'h2000_0000, 4'hF);
        wr(16'h0C, 32'h0, 4'hF);
        wr(16'h04, 32'h2, 4'h1);
        cyc_start = cyc;
        wait_rise("pass_rise_latency");
        check("pass_dram_base", dram_base, 32'h2000_0000);
        check("pass_entry_pc", entry_pc, 32'h0);
        repeat (5) tick();
        snoop(32'h8000_1000, 32'h1);
        check("pass_cpu_halt", 32'(cpu_rst_n), 32'h0);
        rd("pass_status", 16'h00, 32'h36);
        rd("pass_thval", 16'h14, 32'h1);
        rd("pass_cycles", 16'h18, 32'd6);
        rd("ctrl_start_reads0", 16'h04, 32'h0);

        // Fail run, with an ignored even-valued snoop and a wrong address
        wr(16'h04, 32'h2, 4'h1);
        cyc_start = cyc;
        tick();
        rd("fail_rst_status", 16'h00, 32'h10);
        rd("fail_rst_thval", 16'h14, 32'h0);
        rd("fail_rst_cycles", 16'h18, 32'h0);
        wait_rise("fail_rise_latency");
        snoop(32'h8000_1000, 32'h6);
        check("even_snoop_ignored", 32'(cpu_rst_n), 32'h1);
        snoop(32'h8000_1004, 32'h1);
        check("addr_snoop_ignored", 32'(cpu_rst_n), 32'h1);
        rd("fail_run_status", 16'h00, 32'h21);
        snoop(32'h8000_1000, 32'h7);
        check("fail_cpu_halt", 32'(cpu_rst_n), 32'h0);
        rd("fail_status", 16'h00, 32'h32);
        rd("fail_thval", 16'h14, 32'h7);

        // HOLD during RUN
        wr(16'h04, 32'h2, 4'h1);
        cyc_start = cyc;
        wait_rise("hold_rise_latency");
        repeat (3) tick();
        wr(16'h04, 32'h1, 4'h1);
        check("hold_same_cycle", 32'(cpu_rst_n), 32'h1);
        tick();
        check("hold_cpu_rst", 32'(cpu_rst_n), 32'h0);
        rd("hold_cycles", 16'h18, 32'd5);
        rd("hold_status", 16'h00, 32'h08);
        repeat (3) tick();
        rd("hold_cycles_frozen", 16'h18, 32'd5);
        wr(16'h04, 32'h0, 4'h1);

        // Relatch and START ignored during RST
        wr(16'h04, 32'h2, 4'h1);
        cyc_start = cyc;
        repeat (3) tick();
        wr(16'h04, 32'h2, 4'h1);
        wait_rise("rst_start_ignored_latency");
        wr(16'h0C, 32'h100, 4'hF);
        tick();
        check("run_entry_pc_held", entry_pc, 32'h0);
        rd("run_entrypc_reg", 16'h0C, 32'h100);
        rd("rw_same_cycle", 16'h0C, 32'h100);
        snoop(32'h8000_1000, 32'h1);
        wr(16'h04, 32'h2, 4'h1);
        cyc_start = cyc;
        tick();
        check("relatch_entry_pc", entry_pc, 32'h100);
        check("relatch_dram_base", dram_base, 32'h2000_0000);
        wait_rise("relatch_rise_latency");
        tick(); tick();

        // Asynchronous reset mid-RUN
        #3 ARESETN = 1'b0;
        #1;
        check("async_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
        check("async_entry_pc", entry_pc, 32'h0);
        check("async_dram_base", dram_base, 32'h0);
        tick();
        ARESETN = 1'b1;
        tick();
        check_reset_regs("async");

        // Snoop outside RUN is ignored
        snoop(32'h8000_1000, 32'h1);
        rd("idle_snoop_status", 16'h00, 32'h0);
        rd("idle_snoop_thval", 16'h14, 32'h0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
